wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL use these ports (clock and reset first):
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_control_wb  input  2  write-back controls from MEM/WB register; bit1 = RegWrite, bit0 = MemtoReg.
REQ-005 Read_data  input  32  load data from MEM/WB register.
REQ-006 mem_ALU_result  input  32  ALU result from MEM/WB register.
REQ-007 mem_Write_reg  input  5  destination register index from MEM/WB register.
REQ-008 rs_addr  input  5  read port A index (decode stage).
REQ-009 rt_addr  input  5  read port B index (decode stage).
REQ-010 rs_data  output  32  read port A data, combinational.
REQ-011 rt_data  output  32  read port B data, combinational.
REQ-012 wb_data  output  32  selected write-back value, combinational, for forwarding logic.
REQ-013 wb_count  output  32  registered count of committed register writes.

Function
REQ-014 wb_data SHALL equal Read_data when MemtoReg=1, else mem_ALU_result, regardless of RegWrite.
REQ-015 Storage SHALL be 32 x 32-bit registers; entry 0 SHALL always read 0 and never be written.
REQ-016 On a rising clk with rst=0, RegWrite=1 and mem_Write_reg!=0, entry[mem_Write_reg] SHALL take wb_data; write latency one edge.
REQ-017 RegWrite=1 with mem_Write_reg=0 SHALL change no entry and SHALL NOT increment wb_count.
REQ-018 RegWrite=0 SHALL change no entry regardless of other inputs.
REQ-019 rs_data/rt_data SHALL reflect the stored entry combinationally, zero-cycle read latency; both ports independent, same address on both allowed.
REQ-020 wb_count SHALL increment by 1 on each edge that commits a write per REQ-016; wraps 0xFFFFFFFF -> 0x00000000.
REQ-021 Read-during-write to the same nonzero index: behaviour per REQ-026/REQ-027.
REQ-022 Inputs SHALL be consumed as presented each cycle; no handshake, no stall, no internal buffering beyond the storage array and counter.

Reset
REQ-023 rst=1 SHALL asynchronously clear all 32 entries to 0x00000000 and wb_count to 0, independent of clk.
REQ-024 A write presented on an edge while rst=1 SHALL be discarded; after rst deasserts, the first edge with valid controls SHALL commit normally.
REQ-025 During reset rs_data/rt_data SHALL read 0; wb_data stays combinational per REQ-014.

Configuration
REQ-026 With macro WB_BYPASS_EN defined: if RegWrite=1, mem_Write_reg!=0 and mem_Write_reg equals a read index, that port SHALL output wb_data in the same cycle (write-first).
REQ-027 Without WB_BYPASS_EN: that port SHALL output the old stored value until the write edge (read-first); decode-stage hazard logic is then responsible for the gap.

Verification
REQ-028 Reset then rs_addr=5, rt_addr=31 -> rs_data=0, rt_data=0, wb_count=0.
REQ-029 RegWrite=1, MemtoReg=0, ALU=0x1234_5678, Write_reg=8, one edge; then rs_addr=8 -> rs_data=0x12345678, wb_count=1; repeat with MemtoReg=1, Read_data=0xDEAD_BEEF, Write_reg=9 -> rt_addr=9 reads 0xDEADBEEF, wb_count=2.
REQ-030 RegWrite=1, Write_reg=0, ALU=0xFFFF_FFFF, one edge -> rs_addr=0 reads 0, wb_count unchanged.
REQ-031 Entry 10=0x1, then RegWrite=1, Write_reg=10, ALU=0x2, rs_addr=rt_addr=10 before edge -> both ports 0x2 with WB_BYPASS_EN, 0x1 without; after edge both 0x2.
REQ-032 Entry 4=0xAAAA_AAAA, assert rst mid-cycle between edges -> rs_addr=4 reads 0 immediately; write presented while rst=1 not committed; wb_count=0.
REQ-033 Force wb_count to 0xFFFF_FFFF via 2^32-1 writes or backdoor, one more write to Write_reg=3 -> wb_count=0, entry 3 updated.

Source files
------------

// File: rtl/wb_regfile.sv
// MEM/WB write-back stage and 32 x 32 register file with a committed-write counter.
// Optional macro WB_BYPASS_EN makes the read ports write-first (same-cycle forwarding of wb_data).
module wb_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mem_control_wb,
   input  logic [31:0] Read_data,
   input  logic [31:0] mem_ALU_result,
   input  logic [4:0]  mem_Write_reg,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   output logic [31:0] wb_data,
   output logic [31:0] wb_count
);

   logic        regWrite;
   logic        memToReg;
   logic        commit;
   logic [31:0] regFile_q [32];
   logic [31:0] wbCount_q;
   logic [31:0] wbCount_d;

   assign regWrite  = mem_control_wb[1];
   assign memToReg  = mem_control_wb[0];
   assign wb_data   = memToReg ? Read_data : mem_ALU_result;
   // Entry 0 is hardwired to zero simply by never committing a write to it.
   assign commit    = regWrite && (mem_Write_reg != 5'd0);
   assign wbCount_d = wbCount_q + 32'd1;
   assign wb_count  = wbCount_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regFile_q[i] <= 32'h0;
         end
         wbCount_q <= 32'h0;
      end else if (commit) begin
         regFile_q[mem_Write_reg] <= wb_data;
         wbCount_q                <= wbCount_d;
      end
   end

`ifdef WB_BYPASS_EN
   // Bypass is suppressed during reset so the ports keep reading the cleared array.
   always_comb begin
      rs_data = regFile_q[rs_addr];
      rt_data = regFile_q[rt_addr];
      if (!rst && commit && (mem_Write_reg == rs_addr)) begin
         rs_data = wb_data;
      end
      if (!rst && commit && (mem_Write_reg == rt_addr)) begin
         rt_data = wb_data;
      end
   end
`else
   always_comb begin
      rs_data = regFile_q[rs_addr];
      rt_data = regFile_q[rt_addr];
   end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_wb_regfile;

   typedef struct {
      string       name;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] wb;
      logic [31:0] cnt;
   } expect_t;

`ifdef WB_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [1:0]  memControlWb;
   logic [31:0] readData;
   logic [31:0] aluResult;
   logic [4:0]  writeReg;
   logic [4:0]  rsAddr;
   logic [4:0]  rtAddr;
   logic [31:0] rsData;
   logic [31:0] rtData;
   logic [31:0] wbData;
   logic [31:0] wbCount;

   expect_t scoreQ[$];
   int      checkCount;
   int      passCount;
   bit      stimDone;

   wb_regfile dut (
      .clk            (clk),
      .rst            (rst),
      .mem_control_wb (memControlWb),
      .Read_data      (readData),
      .mem_ALU_result (aluResult),
      .mem_Write_reg  (writeReg),
      .rs_addr        (rsAddr),
      .rt_addr        (rtAddr),
      .rs_data        (rsData),
      .rt_data        (rtData),
      .wb_data        (wbData),
      .wb_count       (wbCount)
   );

   // 10-unit clock; rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle's worth of inputs just after the rising edge.
   task automatic applyStimulus(input logic [1:0] ctrl, input logic [31:0] rd,
                                input logic [31:0] alu, input logic [4:0] wr,
                                input logic [4:0] rs, input logic [4:0] rt);
      memControlWb = ctrl;
      readData     = rd;
      aluResult    = alu;
      writeReg     = wr;
      rsAddr       = rs;
      rtAddr       = rt;
   endtask

   task automatic expectOut(input string name, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] wb, input logic [31:0] cnt);
      expect_t e;
      e.name = name;
      e.rs   = rs;
      e.rt   = rt;
      e.wb   = wb;
      e.cnt  = cnt;
      scoreQ.push_back(e);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checkCount++;
      if (actual === required) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
      end
   endtask

   // Monitor: outputs are stable mid-cycle, so compare at the falling edge.
   always @(negedge clk) begin
      while (scoreQ.size() > 0) begin
         expect_t e;
         e = scoreQ.pop_front();
         checkOutput({e.name, ".rs_data"},  rsData,  e.rs);
         checkOutput({e.name, ".rt_data"},  rtData,  e.rt);
         checkOutput({e.name, ".wb_data"},  wbData,  e.wb);
         checkOutput({e.name, ".wb_count"}, wbCount, e.cnt);
      end
   end

   initial begin
      checkCount = 0;
      passCount  = 0;
      stimDone   = 1'b0;
      rst        = 1'b1;
      applyStimulus(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      nextCycle();

      // Reset state; wb_data still muxes combinationally while in reset.
      applyStimulus(2'b01, 32'hCAFE_F00D, 32'h0, 5'd0, 5'd5, 5'd31);
      expectOut("reset", 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0);
      nextCycle();
      rst = 1'b0;

      // ALU-result write to r8.
      applyStimulus(2'b10, 32'h55, 32'h1234_5678, 5'd8, 5'd1, 5'd2);
      expectOut("wrAlu", 32'h0, 32'h0, 32'h1234_5678, 32'd0);
      nextCycle();
      applyStimulus(2'b00, 32'h55, 32'h1234_5678, 5'd8, 5'd8, 5'd9);
      expectOut("rdR8", 32'h1234_5678, 32'h0, 32'h1234_5678, 32'd1);
      nextCycle();

      // Load-data write to r9.
      applyStimulus(2'b11, 32'hDEAD_BEEF, 32'h77, 5'd9, 5'd8, 5'd3);
      expectOut("wrMem", 32'h1234_5678, 32'h0, 32'hDEAD_BEEF, 32'd1);
      nextCycle();
      applyStimulus(2'b00, 32'hDEAD_BEEF, 32'h77, 5'd9, 5'd8, 5'd9);
      expectOut("rdR9", 32'h1234_5678, 32'hDEAD_BEEF, 32'h77, 32'd2);
      nextCycle();

      // RegWrite=0 with MemtoReg=1 must leave r8 alone.
      applyStimulus(2'b01, 32'h1111_1111, 32'h77, 5'd8, 5'd8, 5'd0);
      expectOut("noWr", 32'h1234_5678, 32'h0, 32'h1111_1111, 32'd2);
      nextCycle();
      applyStimulus(2'b00, 32'h0, 32'h77, 5'd8, 5'd8, 5'd0);
      expectOut("noWrAfter", 32'h1234_5678, 32'h0, 32'h77, 32'd2);
      nextCycle();

      // Write to r0 is ignored and not counted.
      applyStimulus(2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
      expectOut("wrR0", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd2);
      nextCycle();
      applyStimulus(2'b00, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
      expectOut("rdR0", 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd2);
      nextCycle();

      // Read-during-write on r10 from both ports.
      applyStimulus(2'b10, 32'h0, 32'h1, 5'd10, 5'd8, 5'd9);
      expectOut("wrR10a", 32'h1234_5678, 32'hDEAD_BEEF, 32'h1, 32'd2);
      nextCycle();
      applyStimulus(2'b10, 32'h0, 32'h2, 5'd10, 5'd10, 5'd10);
      expectOut("rdw", Bypass ? 32'h2 : 32'h1, Bypass ? 32'h2 : 32'h1, 32'h2, 32'd3);
      nextCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 5'd10, 5'd10, 5'd10);
      expectOut("rdwAfter", 32'h2, 32'h2, 32'h0, 32'd4);
      nextCycle();

      // Fill r4, then assert reset mid-cycle with a write pending.
      applyStimulus(2'b10, 32'h0, 32'hAAAA_AAAA, 5'd4, 5'd4, 5'd10);
      expectOut("wrR4", Bypass ? 32'hAAAA_AAAA : 32'h0, 32'h2, 32'hAAAA_AAAA, 32'd4);
      nextCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 5'd4, 5'd4, 5'd10);
      expectOut("rdR4", 32'hAAAA_AAAA, 32'h2, 32'h0, 32'd5);
      nextCycle();
      applyStimulus(2'b10, 32'h0, 32'hBBBB_BBBB, 5'd4, 5'd4, 5'd10);
      #1;
      rst = 1'b1;
      expectOut("midRst", 32'h0, 32'h0, 32'hBBBB_BBBB, 32'd0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(2'b00, 32'h0, 32'h0, 5'd4, 5'd4, 5'd10);
      expectOut("rstDiscard", 32'h0, 32'h0, 32'h0, 32'd0);
      nextCycle();

      // First write after reset commits normally.
      applyStimulus(2'b10, 32'h0, 32'h33, 5'd3, 5'd3, 5'd4);
      expectOut("postRstWr", Bypass ? 32'h33 : 32'h0, 32'h0, 32'h33, 32'd0);
      nextCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 5'd3, 5'd3, 5'd4);
      expectOut("postRstRd", 32'h33, 32'h0, 32'h0, 32'd1);
      nextCycle();

      // Counter wrap: preload the counter through a backdoor, then one more write.
      force dut.wbCount_q = 32'hFFFF_FFFF;
      #1;
      release dut.wbCount_q;
      applyStimulus(2'b10, 32'h0, 32'h44, 5'd3, 5'd3, 5'd0);
      expectOut("wrapWr", Bypass ? 32'h44 : 32'h33, 32'h0, 32'h44, 32'hFFFF_FFFF);
      nextCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0);
      expectOut("wrapRd", 32'h44, 32'h0, 32'h0, 32'h0);
      nextCycle();

      nextCycle();
      stimDone = 1'b1;
   end

   // Summary once the monitor has drained the scoreboard, with a hard time limit.
   initial begin
      fork
         begin
            wait (stimDone && scoreQ.size() == 0);
         end
         begin
            #20000;
            checkCount++;
            $display("[TB] FAIL timeout: stimDone=%0d, pending=%0d, expected stimDone=1 pending=0",
                     stimDone, scoreQ.size());
         end
      join_any
      disable fork;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
